// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port controller in front of a single-port 256x8 RAM. The instruction
// fetch port (IF_*) and the data port (DA_*) are arbitrated round-robin. The
// winner's address, direction and write data are latched onto MAR/RNW/BUS_OUT.
// The controller then runs the RAM ENABLE/MFC handshake and returns a
// one-cycle ACK to the winner. A watchdog aborts an access whose MFC never
// arrives. When that happens, ERR is raised with the ACK and reads return 8'hFF.
//
// Parameters
//   TIMEOUT   ACCESS cycles without MFC before the access is aborted (2..255)
//
// Ports
//   CLK                 system clock, all state on the rising edge
//   RSTn                asynchronous active-low reset
//   IF_REQ, IF_ADDR     fetch request / address (read-only port)
//   DA_REQ, DA_ADDR     data request / address
//   DA_RNW, DA_WDATA    data direction (1 = read) / write data
//   IF_ACK, DA_ACK      one-cycle completion pulses
//   IF_RDATA, DA_RDATA  read data, held until the next ACK to that port
//   ERR                 pulses with ACK when the access timed out
//   MAR, RNW, BUS_OUT   RAM address, direction and write data
//   ENABLE              RAM enable
//   BUS_OE              BUS_OUT drives the shared bus (write ACCESS only)
//   MBR, MFC            RAM read data and memory-function-complete
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       IF_REQ,
    input  logic [7:0] IF_ADDR,
    input  logic       DA_REQ,
    input  logic [7:0] DA_ADDR,
    input  logic       DA_RNW,
    input  logic [7:0] DA_WDATA,
    output logic       IF_ACK,
    output logic       DA_ACK,
    output logic [7:0] IF_RDATA,
    output logic [7:0] DA_RDATA,
    output logic       ERR,
    output logic [7:0] MAR,
    output logic       ENABLE,
    output logic       RNW,
    output logic [7:0] BUS_OUT,
    output logic       BUS_OE,
    input  logic [7:0] MBR,
    input  logic       MFC
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Last watchdog count before the access is given up.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state_r;
    logic [7:0] cnt_r;
    logic       winner_da_r;   // 1 = data port owns the current access
    logic       last_da_r;     // 1 = data port was granted last (reset: favour fetch)
    logic       abort_r;       // current access ended by the watchdog
    logic       grant_da_s;
    logic       any_req_s;

    // Round-robin arbitration of the two request lines.
    always_comb begin
        grant_da_s = 1'b0;
        any_req_s  = IF_REQ | DA_REQ;
        if (IF_REQ && DA_REQ) begin
            grant_da_s = ~last_da_r;
        end else if (DA_REQ) begin
            grant_da_s = 1'b1;
        end else begin
            grant_da_s = 1'b0;
        end
    end

    // Access sequencer: grant, RAM handshake, watchdog and acknowledge.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            winner_da_r <= 1'b0;
            last_da_r   <= 1'b1;
            abort_r     <= 1'b0;
            IF_ACK      <= 1'b0;
            DA_ACK      <= 1'b0;
            IF_RDATA    <= 8'h00;
            DA_RDATA    <= 8'h00;
            ERR         <= 1'b0;
            MAR         <= 8'h00;
            ENABLE      <= 1'b0;
            RNW         <= 1'b1;
            BUS_OUT     <= 8'h00;
            BUS_OE      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    IF_ACK <= 1'b0;
                    DA_ACK <= 1'b0;
                    ERR    <= 1'b0;
                    if (any_req_s) begin
                        winner_da_r <= grant_da_s;
                        // The fetch port is read-only, so it never drives the bus.
                        MAR         <= grant_da_s ? DA_ADDR  : IF_ADDR;
                        RNW         <= grant_da_s ? DA_RNW   : 1'b1;
                        BUS_OUT     <= grant_da_s ? DA_WDATA : 8'h00;
                        state_r     <= ST_SETUP;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    // Address and direction have been stable for a full cycle.
                    ENABLE  <= 1'b1;
                    BUS_OE  <= ~RNW;
                    cnt_r   <= 8'd0;
                    state_r <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (MFC) begin
                        if (RNW) begin
                            if (winner_da_r) begin
                                DA_RDATA <= MBR;
                            end else begin
                                IF_RDATA <= MBR;
                            end
                        end
                        ENABLE  <= 1'b0;
                        BUS_OE  <= 1'b0;
                        state_r <= ST_RELEASE;
                    end else if (cnt_r == TMO_LAST) begin
                        abort_r <= 1'b1;
                        if (RNW) begin
                            if (winner_da_r) begin
                                DA_RDATA <= 8'hFF;
                            end else begin
                                IF_RDATA <= 8'hFF;
                            end
                        end
                        ENABLE  <= 1'b0;
                        BUS_OE  <= 1'b0;
                        state_r <= ST_RELEASE;
                    end else begin
                        cnt_r   <= cnt_r + 8'd1;
                    end
                end
                ST_RELEASE: begin
                    // Wait for the RAM to drop MFC before acknowledging.
                    if (!MFC) begin
                        IF_ACK  <= ~winner_da_r;
                        DA_ACK  <= winner_da_r;
                        ERR     <= abort_r;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RELEASE;
                    end
                end
                ST_DONE: begin
                    IF_ACK    <= 1'b0;
                    DA_ACK    <= 1'b0;
                    ERR       <= 1'b0;
                    abort_r   <= 1'b0;
                    last_da_r <= winner_da_r;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    // Unreachable encoding: park safely with the RAM disabled.
                    IF_ACK    <= 1'b0;
                    DA_ACK    <= 1'b0;
                    ERR       <= 1'b0;
                    abort_r   <= 1'b0;
                    ENABLE    <= 1'b0;
                    BUS_OE    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter. It contains a behavioural RAM with a programmable MFC
// delay, an MFC hold-after-release time and a no-response mode. It also keeps
// a reference model made of a shadow memory, the round-robin winner rule, the
// expected RDATA per port and the latency formula.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int TMO = 16;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       IF_REQ, DA_REQ, DA_RNW;
    logic [7:0] IF_ADDR, DA_ADDR, DA_WDATA;
    logic       IF_ACK, DA_ACK, ERR, ENABLE, RNW, BUS_OE, MFC;
    logic [7:0] IF_RDATA, DA_RDATA, MAR, BUS_OUT, MBR;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.TIMEOUT(TMO)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR),
        .DA_REQ(DA_REQ), .DA_ADDR(DA_ADDR), .DA_RNW(DA_RNW), .DA_WDATA(DA_WDATA),
        .IF_ACK(IF_ACK), .DA_ACK(DA_ACK), .IF_RDATA(IF_RDATA), .DA_RDATA(DA_RDATA),
        .ERR(ERR), .MAR(MAR), .ENABLE(ENABLE), .RNW(RNW),
        .BUS_OUT(BUS_OUT), .BUS_OE(BUS_OE), .MBR(MBR), .MFC(MFC)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural RAM ----------------
    logic [7:0] ram [256];
    bit         ram_loaded = 1'b0;
    logic [7:0] salt = 8'h00;
    int         mfc_delay = 0;
    int         mfc_hold  = 0;
    bit         mfc_off   = 1'b0;
    int         acc_cnt   = 0;
    int         hold_cnt  = 0;

    function automatic logic [7:0] seed_val(input int a, input logic [7:0] s);
        logic [7:0] v;
        v = 8'(a * 37 + 11);
        return v ^ s;
    endfunction

    assign MFC = !mfc_off && ((ENABLE && (acc_cnt >= mfc_delay)) || (hold_cnt != 0));
    assign MBR = ram[MAR];

    // RAM timing and storage.
    always @(posedge CLK) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= seed_val(i, salt);
            ram_loaded <= 1'b1;
        end
        if (ENABLE) acc_cnt <= acc_cnt + 1;
        else        acc_cnt <= 0;
        if (ENABLE && MFC) begin
            hold_cnt <= mfc_hold;
            if (!RNW) ram[MAR] <= BUS_OUT;
        end else if (hold_cnt != 0) begin
            hold_cnt <= hold_cnt - 1;
        end
    end

    // ---------------- activity monitor ----------------
    int         en_cnt  = 0;
    int         oe_cnt  = 0;
    int         bus_bad = 0;
    logic [7:0] exp_wdata = 8'h00;

    // Count enable/drive cycles and flag bad write-bus contents.
    always @(posedge CLK) begin
        if (ENABLE) en_cnt <= en_cnt + 1;
        if (BUS_OE) begin
            oe_cnt <= oe_cnt + 1;
            if (BUS_OUT !== exp_wdata || RNW !== 1'b0 || ENABLE !== 1'b1)
                bus_bad <= bus_bad + 1;
        end
    end

    // ---------------- reference model state ----------------
    logic [7:0] ref_mem [256];
    bit         last_da      = 1'b1;
    logic [7:0] exp_if_rdata = 8'h00;
    logic [7:0] exp_da_rdata = 8'h00;

    function automatic bit pick_da(input bit rq_if, input bit rq_da, input bit last);
        if (rq_if && rq_da) return !last;
        return rq_da;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_mar", {24'd0, MAR}, 32'h0);
        check("rst_enable", {31'd0, ENABLE}, 32'h0);
        check("rst_rnw", {31'd0, RNW}, 32'h1);
        check("rst_bus_out", {24'd0, BUS_OUT}, 32'h0);
        check("rst_bus_oe", {31'd0, BUS_OE}, 32'h0);
        check("rst_acks", {30'd0, IF_ACK, DA_ACK}, 32'h0);
        check("rst_err", {31'd0, ERR}, 32'h0);
        check("rst_if_rdata", {24'd0, IF_RDATA}, 32'h0);
        check("rst_da_rdata", {24'd0, DA_RDATA}, 32'h0);
    endtask

    // One access from request to the cycle after ACK; called at a negedge in IDLE.
    task automatic do_access(input bit rq_if, input bit rq_da, input bit rnw,
                             input logic [7:0] a_if, input logic [7:0] a_da,
                             input logic [7:0] wd, input int dly, input int hld,
                             input bit tmo, input bit drop, input bit keep);
        bit         win_da, rd, got;
        logic [7:0] addr;
        int         n, en0, oe0, bb0, exp_cyc, exp_en;
        mfc_delay = dly;
        mfc_hold  = hld;
        mfc_off   = tmo;
        win_da    = pick_da(rq_if, rq_da, last_da);
        addr      = win_da ? a_da : a_if;
        rd        = win_da ? rnw : 1'b1;
        exp_wdata = wd;
        IF_REQ = rq_if; DA_REQ = rq_da;
        IF_ADDR = a_if; DA_ADDR = a_da; DA_RNW = rnw; DA_WDATA = wd;
        en0 = en_cnt; oe0 = oe_cnt; bb0 = bus_bad;
        n = 0; got = 1'b0;
        while (n < 300 && !got) begin
            @(posedge CLK);
            @(negedge CLK);
            n++;
            if (n == 1 && drop) begin
                IF_REQ = 1'b0; DA_REQ = 1'b0;
                IF_ADDR = ~a_if; DA_ADDR = ~a_da; DA_WDATA = ~wd; DA_RNW = ~rnw;
            end
            if (IF_ACK || DA_ACK) got = 1'b1;
        end
        if (tmo) begin
            exp_cyc = TMO + 3;
            exp_en  = TMO;
            if (rd) begin
                if (win_da) exp_da_rdata = 8'hFF;
                else        exp_if_rdata = 8'hFF;
            end
        end else begin
            exp_cyc = 4 + dly + hld;
            exp_en  = dly + 1;
            if (rd) begin
                if (win_da) exp_da_rdata = ref_mem[addr];
                else        exp_if_rdata = ref_mem[addr];
            end else begin
                ref_mem[addr] = wd;
            end
        end
        check("ack_port", {30'd0, IF_ACK, DA_ACK}, win_da ? 32'h1 : 32'h2);
        check("latency", n, exp_cyc);
        check("err", {31'd0, ERR}, {31'd0, tmo});
        check("if_rdata", {24'd0, IF_RDATA}, {24'd0, exp_if_rdata});
        check("da_rdata", {24'd0, DA_RDATA}, {24'd0, exp_da_rdata});
        check("mar", {24'd0, MAR}, {24'd0, addr});
        check("enable_at_ack", {31'd0, ENABLE}, 32'h0);
        check("enable_cycles", en_cnt - en0, exp_en);
        check("bus_oe_cycles", oe_cnt - oe0, rd ? 0 : exp_en);
        check("bus_contents", bus_bad - bb0, 0);
        last_da = win_da;
        if (!keep) begin
            IF_REQ = 1'b0; DA_REQ = 1'b0;
        end
        @(posedge CLK);
        @(negedge CLK);
        check("ack_one_cycle", {29'd0, IF_ACK, DA_ACK, ERR}, 32'h0);
    endtask

    initial begin
        int acks_seen;
        bit en_seen;
        salt = 8'($urandom);
        for (int i = 0; i < 256; i++) ref_mem[i] = seed_val(i, salt);
        RSTn = 1'b0;
        IF_REQ = 1'b0; DA_REQ = 1'b0; DA_RNW = 1'b1;
        IF_ADDR = 8'h00; DA_ADDR = 8'h00; DA_WDATA = 8'h00;
        repeat (3) @(negedge CLK);
        check_reset_values();
        RSTn = 1'b1;
        @(negedge CLK);

        // Nominal fetch of address 8.
        do_access(1'b1, 1'b0, 1'b1, 8'h08, 8'h00, 8'h00, 0, 0, 1'b0, 1'b0, 1'b0);
        // Data write then read back of 0x20.
        do_access(1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 8'h5A, 0, 0, 1'b0, 1'b0, 1'b0);
        do_access(1'b0, 1'b1, 1'b1, 8'h00, 8'h20, 8'h00, 1, 1, 1'b0, 1'b0, 1'b0);

        // Random single-port traffic with random RAM timing.
        for (int k = 0; k < 10; k++) begin
            bit use_da;
            use_da = 1'($urandom_range(0, 1));
            do_access(!use_da, use_da, 1'($urandom_range(0, 1)),
                      8'($urandom), 8'($urandom), 8'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                      1'b0, 1'b0, 1'b0);
        end

        // Watchdog on a fetch, recovery, watchdog on a data write.
        do_access(1'b1, 1'b0, 1'b1, 8'($urandom), 8'h00, 8'h00, 0, 0, 1'b1, 1'b0, 1'b0);
        do_access(1'b0, 1'b1, 1'b1, 8'h00, 8'($urandom), 8'h00, 2, 0, 1'b0, 1'b0, 1'b0);
        do_access(1'b0, 1'b1, 1'b0, 8'h00, 8'h44, 8'($urandom), 0, 0, 1'b1, 1'b0, 1'b0);
        do_access(1'b0, 1'b1, 1'b1, 8'h00, 8'h44, 8'h00, 0, 0, 1'b0, 1'b0, 1'b0);

        // Request dropped during SETUP: latched address is used.
        do_access(1'b0, 1'b1, 1'b1, 8'h00, 8'h33, 8'h77, 1, 1, 1'b0, 1'b1, 1'b0);
        // Fetch last, so only a reset can point arbitration back at fetch.
        do_access(1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 8'h00, 0, 0, 1'b0, 1'b0, 1'b0);

        // Reset during the ACCESS phase of a write.
        mfc_off = 1'b1;
        DA_REQ = 1'b1; DA_RNW = 1'b0; DA_ADDR = 8'h55; DA_WDATA = 8'hC3;
        en_seen = 1'b0;
        for (int c = 0; c < 10 && !en_seen; c++) begin
            @(posedge CLK);
            #1;
            if (ENABLE === 1'b1) en_seen = 1'b1;
        end
        check("enable_before_reset", {31'd0, en_seen}, 32'h1);
        #1 RSTn = 1'b0;
        #1;
        check("async_enable_drop", {31'd0, ENABLE}, 32'h0);
        check("async_bus_oe_drop", {31'd0, BUS_OE}, 32'h0);
        DA_REQ = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        check_reset_values();
        acks_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (IF_ACK || DA_ACK) acks_seen++;
        end
        check("no_ack_after_reset", acks_seen, 0);
        last_da = 1'b1;
        exp_if_rdata = 8'h00;
        exp_da_rdata = 8'h00;
        mfc_off = 1'b0;

        // Both ports held continuously: grants alternate, fetch first.
        for (int k = 0; k < 4; k++) begin
            do_access(1'b1, 1'b1, 1'($urandom_range(0, 1)),
                      8'(8'h80 + k), 8'(8'h90 + k), 8'($urandom),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
                      1'b0, 1'b0, (k < 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
